// File: rtl/complex_multiply_pipe.sv
// Pipelined complex multiplier with optional conjugate of operand 1, round/shift,
// output saturation and valid/ready backpressure. Latency is PIPE_STAGES cycles.
module complex_multiply_pipe #(
  parameter int IN_WIDTH    = 16,
  parameter int OUT_WIDTH   = 32,
  parameter int SHIFT       = 0,
  parameter int PIPE_STAGES = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [IN_WIDTH-1:0]  i0_in,
  input  logic [IN_WIDTH-1:0]  q0_in,
  input  logic [IN_WIDTH-1:0]  i1_in,
  input  logic [IN_WIDTH-1:0]  q1_in,
  input  logic                 conj_in,
  input  logic                 last_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic [OUT_WIDTH-1:0] i_out,
  output logic [OUT_WIDTH-1:0] q_out,
  output logic                 last_out,
  output logic                 sat_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  input  logic                 clear_in,
  output logic                 sat_sticky_out
);

  localparam int PW = 2 * IN_WIDTH;
  localparam int SW = PW + 1;
  // One extra bit over the sum so the rounding constant can never overflow.
  localparam int RW = SW + 1;

  localparam logic signed [RW-1:0] ONE     = RW'(1);
  localparam logic signed [RW-1:0] OUT_MAX = (ONE <<< (OUT_WIDTH - 1)) - ONE;
  localparam logic signed [RW-1:0] OUT_MIN = -(ONE <<< (OUT_WIDTH - 1));
  localparam logic signed [RW-1:0] RND     = (ONE <<< SHIFT) >>> 1;

  logic adv;

  logic                       s1_valid, s1_conj, s1_last;
  logic signed [IN_WIDTH-1:0] s1_i0, s1_q0, s1_i1, s1_q1;

  logic                 s2_valid, s2_conj, s2_last;
  logic signed [PW-1:0] s2_ii, s2_qq, s2_iq, s2_qi;

  logic signed [SW-1:0]        sum_i, sum_q;
  logic signed [RW-1:0]        sh_i, sh_q, cl_i, cl_q;
  logic                        sat_i, sat_q;
  logic signed [OUT_WIDTH-1:0] res_i, res_q;

  logic                        st_valid [3:PIPE_STAGES];
  logic                        st_last  [3:PIPE_STAGES];
  logic                        st_sat   [3:PIPE_STAGES];
  logic signed [OUT_WIDTH-1:0] st_i     [3:PIPE_STAGES];
  logic signed [OUT_WIDTH-1:0] st_q     [3:PIPE_STAGES];

  assign adv       = !valid_out || ready_in;
  assign ready_out = adv;

  always_comb begin
    sum_i = '0;
    sum_q = '0;
    if (s2_conj) begin
      sum_i = SW'(s2_ii) + SW'(s2_qq);
      sum_q = SW'(s2_qi) - SW'(s2_iq);
    end else begin
      sum_i = SW'(s2_ii) - SW'(s2_qq);
      sum_q = SW'(s2_iq) + SW'(s2_qi);
    end
    sh_i = (RW'(sum_i) + RND) >>> SHIFT;
    sh_q = (RW'(sum_q) + RND) >>> SHIFT;

    cl_i  = sh_i;
    sat_i = 1'b0;
    if (sh_i > OUT_MAX) begin
      cl_i  = OUT_MAX;
      sat_i = 1'b1;
    end else if (sh_i < OUT_MIN) begin
      cl_i  = OUT_MIN;
      sat_i = 1'b1;
    end
    cl_q  = sh_q;
    sat_q = 1'b0;
    if (sh_q > OUT_MAX) begin
      cl_q  = OUT_MAX;
      sat_q = 1'b1;
    end else if (sh_q < OUT_MIN) begin
      cl_q  = OUT_MIN;
      sat_q = 1'b1;
    end
    res_i = OUT_WIDTH'(cl_i);
    res_q = OUT_WIDTH'(cl_q);
  end

  // The whole pipeline moves together on adv; a stalled output freezes every stage.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0;
      s1_conj  <= 1'b0;
      s1_last  <= 1'b0;
      s1_i0    <= '0;
      s1_q0    <= '0;
      s1_i1    <= '0;
      s1_q1    <= '0;
      s2_valid <= 1'b0;
      s2_conj  <= 1'b0;
      s2_last  <= 1'b0;
      s2_ii    <= '0;
      s2_qq    <= '0;
      s2_iq    <= '0;
      s2_qi    <= '0;
      for (int k = 3; k <= PIPE_STAGES; k++) begin
        st_valid[k] <= 1'b0;
        st_last[k]  <= 1'b0;
        st_sat[k]   <= 1'b0;
        st_i[k]     <= '0;
        st_q[k]     <= '0;
      end
    end else if (adv) begin
      s1_valid <= valid_in;
      s1_conj  <= conj_in;
      s1_last  <= last_in;
      s1_i0    <= i0_in;
      s1_q0    <= q0_in;
      s1_i1    <= i1_in;
      s1_q1    <= q1_in;
      s2_valid <= s1_valid;
      s2_conj  <= s1_conj;
      s2_last  <= s1_last;
      s2_ii    <= s1_i0 * s1_i1;
      s2_qq    <= s1_q0 * s1_q1;
      s2_iq    <= s1_i0 * s1_q1;
      s2_qi    <= s1_q0 * s1_i1;
      st_valid[3] <= s2_valid;
      st_last[3]  <= s2_last;
      st_sat[3]   <= sat_i || sat_q;
      st_i[3]     <= res_i;
      st_q[3]     <= res_q;
      for (int k = 4; k <= PIPE_STAGES; k++) begin
        st_valid[k] <= st_valid[k-1];
        st_last[k]  <= st_last[k-1];
        st_sat[k]   <= st_sat[k-1];
        st_i[k]     <= st_i[k-1];
        st_q[k]     <= st_q[k-1];
      end
    end
  end

  // A saturated beat that completes in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sat_sticky_out <= 1'b0;
    end else if (valid_out && ready_in && sat_out) begin
      sat_sticky_out <= 1'b1;
    end else if (clear_in) begin
      sat_sticky_out <= 1'b0;
    end
  end

  assign valid_out = st_valid[PIPE_STAGES];
  assign last_out  = st_last[PIPE_STAGES];
  assign sat_out   = st_sat[PIPE_STAGES];
  assign i_out     = st_i[PIPE_STAGES];
  assign q_out     = st_q[PIPE_STAGES];

endmodule

// File: tb/tb_complex_multiply_pipe.sv
// Scoreboard bench for complex_multiply_pipe: a default instance and a 16-bit/SHIFT=15
// instance share all inputs, and a negedge monitor checks both against a reference model.
module tb_complex_multiply_pipe;

  typedef struct {
    longint i, q, i2, q2;
    bit     sat, sat2, last;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] i0_in, q0_in, i1_in, q1_in;
  logic        conj_in, last_in, valid_in, ready_in, clear_in;
  logic        ready_out, last_out, sat_out, valid_out, sat_sticky_out;
  logic [31:0] i_out, q_out;
  logic        ready_out2, last_out2, sat_out2, valid_out2, sat_sticky_out2;
  logic [15:0] i_out2, q_out2;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   exp_sticky = 1'b0;
  bit   exp_sticky2 = 1'b0;
  bit   ready_req = 1'b1;
  bit   bp_en = 1'b0;
  bit   mon_en = 1'b0;

  complex_multiply_pipe dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .i0_in(i0_in), .q0_in(q0_in), .i1_in(i1_in), .q1_in(q1_in),
    .conj_in(conj_in), .last_in(last_in), .valid_in(valid_in), .ready_out(ready_out),
    .i_out(i_out), .q_out(q_out), .last_out(last_out), .sat_out(sat_out),
    .valid_out(valid_out), .ready_in(ready_in), .clear_in(clear_in),
    .sat_sticky_out(sat_sticky_out)
  );

  complex_multiply_pipe #(.IN_WIDTH(16), .OUT_WIDTH(16), .SHIFT(15), .PIPE_STAGES(3)) dut2 (
    .clk_in(clk_in), .rst_in(rst_in),
    .i0_in(i0_in), .q0_in(q0_in), .i1_in(i1_in), .q1_in(q1_in),
    .conj_in(conj_in), .last_in(last_in), .valid_in(valid_in), .ready_out(ready_out2),
    .i_out(i_out2), .q_out(q_out2), .last_out(last_out2), .sat_out(sat_out2),
    .valid_out(valid_out2), .ready_in(ready_in), .clear_in(clear_in),
    .sat_sticky_out(sat_sticky_out2)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input longint i0, input longint q0, input longint i1,
                                input longint q1, input bit cj, input int ow, input int sh,
                                output longint ri, output longint rq, output bit st);
    longint si, sq, mx, mn;
    if (!cj) begin
      si = i0 * i1 - q0 * q1;
      sq = i0 * q1 + q0 * i1;
    end else begin
      si = i0 * i1 + q0 * q1;
      sq = q0 * i1 - i0 * q1;
    end
    if (sh > 0) begin
      si = si + (64'sd1 <<< (sh - 1));
      sq = sq + (64'sd1 <<< (sh - 1));
    end
    si = si >>> sh;
    sq = sq >>> sh;
    mx = (64'sd1 <<< (ow - 1)) - 1;
    mn = -(64'sd1 <<< (ow - 1));
    st = 1'b0;
    ri = si;
    rq = sq;
    if (si > mx) begin ri = mx; st = 1'b1; end
    if (si < mn) begin ri = mn; st = 1'b1; end
    if (sq > mx) begin rq = mx; st = 1'b1; end
    if (sq < mn) begin rq = mn; st = 1'b1; end
  endfunction

  // Called at posedge+1; holds the beat until accepted, then pushes its expected result.
  task automatic applyStimulus(input logic signed [15:0] i0, input logic signed [15:0] q0,
                               input logic signed [15:0] i1, input logic signed [15:0] q1,
                               input bit cj, input bit lst);
    exp_t e;
    bit   acc = 1'b0;
    i0_in = i0; q0_in = q0; i1_in = i1; q1_in = q1;
    conj_in = cj; last_in = lst; valid_in = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk_in);
      acc = ready_out;
      @(posedge clk_in);
      #1;
    end
    if (acc) begin
      model(i0, q0, i1, q1, cj, 32, 0, e.i, e.q, e.sat);
      model(i0, q0, i1, q1, cj, 16, 15, e.i2, e.q2, e.sat2);
      e.last = lst;
      sb.push_back(e);
    end else begin
      checkOutput("accept timeout", 0, 1);
    end
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 300 && sb.size() > 0; n++) begin
      @(posedge clk_in);
      #1;
    end
    checkOutput("drain remaining beats", sb.size(), 0);
  endtask

  task automatic waitValid(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk_in);
      seen = valid_out;
      if (!seen) begin
        @(posedge clk_in);
        #1;
      end
    end
  endtask

  // Only this process drives ready_in; the pattern 1,0,0,1 repeats while bp_en is set.
  initial begin
    bit [3:0] pat;
    int       idx = 0;
    pat = 4'b1001;
    ready_in = 1'b1;
    forever begin
      @(posedge clk_in);
      #1;
      if (bp_en) begin
        ready_in = pat[idx % 4];
        idx++;
      end else begin
        ready_in = ready_req;
      end
    end
  end

  // Monitor sits on the negedge, just ahead of the edge where the handshake completes.
  always @(negedge clk_in) begin
    exp_t e;
    bit   nxt, nxt2;
    if (rst_in) begin
      sb.delete();
      exp_sticky  = 1'b0;
      exp_sticky2 = 1'b0;
    end else if (mon_en) begin
      checkOutput("sat_sticky_out", sat_sticky_out, exp_sticky);
      checkOutput("sat_sticky_out w16", sat_sticky_out2, exp_sticky2);
      nxt  = exp_sticky;
      nxt2 = exp_sticky2;
      if (clear_in) begin
        nxt  = 1'b0;
        nxt2 = 1'b0;
      end
      if (valid_out) begin
        if (sb.size() == 0) begin
          checkOutput("spurious valid_out", 1, 0);
        end else begin
          e = sb[0];
          checkOutput("i_out", $signed(i_out), e.i);
          checkOutput("q_out", $signed(q_out), e.q);
          checkOutput("sat_out", sat_out, e.sat);
          checkOutput("last_out", last_out, e.last);
          checkOutput("valid_out w16", valid_out2, 1);
          checkOutput("i_out w16", $signed(i_out2), e.i2);
          checkOutput("q_out w16", $signed(q_out2), e.q2);
          checkOutput("sat_out w16", sat_out2, e.sat2);
          checkOutput("last_out w16", last_out2, e.last);
          if (!ready_in) begin
            checkOutput("ready_out while stalled", ready_out, 0);
          end else begin
            if (e.sat)  nxt  = 1'b1;
            if (e.sat2) nxt2 = 1'b1;
            void'(sb.pop_front());
          end
        end
      end
      exp_sticky  = nxt;
      exp_sticky2 = nxt2;
    end
  end

  initial begin
    int          lat;
    bit          seen;
    logic [31:0] r0, r1;
    rst_in = 1'b1;
    valid_in = 1'b0; clear_in = 1'b0; conj_in = 1'b0; last_in = 1'b0;
    i0_in = '0; q0_in = '0; i1_in = '0; q1_in = '0;
    #1;
    checkOutput("reset valid_out", valid_out, 0);
    checkOutput("reset i_out", i_out, 0);
    checkOutput("reset q_out", q_out, 0);
    checkOutput("reset last_out", last_out, 0);
    checkOutput("reset sat_out", sat_out, 0);
    checkOutput("reset sat_sticky_out", sat_sticky_out, 0);
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    mon_en = 1'b1;

    $display("[TB] basic product and latency");
    applyStimulus(3, 4, 5, -2, 1'b0, 1'b1);
    valid_in = 1'b0;
    lat = 1;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk_in);
      seen = valid_out;
      if (!seen) begin
        @(posedge clk_in);
        lat++;
      end
    end
    checkOutput("accept-to-valid latency", lat, 3);
    @(posedge clk_in);
    #1;
    waitDrain();

    $display("[TB] conjugate and interleaved modes");
    applyStimulus(3, 4, 5, -2, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(16'(k * 7 - 20), 16'(3 - k), 16'(k + 2), 16'(-k * 5), k[0], k == 5);
    end
    valid_in = 1'b0;
    waitDrain();

    $display("[TB] saturation");
    applyStimulus(-32768, -32768, -32768, -32768, 1'b1, 1'b0);
    valid_in = 1'b0;
    waitDrain();
    @(negedge clk_in);
    checkOutput("sticky after saturation", sat_sticky_out, 1);
    @(posedge clk_in);
    #1;
    clear_in = 1'b1;
    @(posedge clk_in);
    #1;
    clear_in = 1'b0;
    @(negedge clk_in);
    checkOutput("sticky after clear", sat_sticky_out, 0);
    @(posedge clk_in);
    #1;

    $display("[TB] rounding on the shifted instance");
    applyStimulus(16384, 0, 16384, 0, 1'b0, 1'b0);
    applyStimulus(1, 0, 1, 0, 1'b0, 1'b1);
    applyStimulus(-1, 0, 1, 0, 1'b0, 1'b0);
    valid_in = 1'b0;
    waitDrain();

    $display("[TB] backpressure stream");
    bp_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      r0 = $urandom;
      r1 = $urandom;
      applyStimulus(r0[15:0], r0[31:16], r1[15:0], r1[31:16], r1[5], k == 3 || k == 7);
    end
    valid_in = 1'b0;
    waitDrain();
    bp_en = 1'b0;
    @(posedge clk_in);
    #1;

    $display("[TB] reset with beats in flight");
    ready_req = 1'b0;
    @(posedge clk_in);
    #1;
    applyStimulus(100, 1, 2, 3, 1'b0, 1'b1);
    applyStimulus(-5, 6, 7, -8, 1'b1, 1'b0);
    valid_in = 1'b0;
    waitValid(seen);
    checkOutput("stalled beat reached output", seen, 1);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    #1;
    checkOutput("valid_out during reset", valid_out, 0);
    checkOutput("i_out during reset", i_out, 0);
    ready_req = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    repeat (6) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("no stale beat after reset", valid_out, 0);
    @(posedge clk_in);
    #1;

    $display("[TB] clear and set in the same cycle");
    clear_in = 1'b1;
    applyStimulus(-32768, -32768, -32768, -32768, 1'b1, 1'b0);
    valid_in = 1'b0;
    waitValid(seen);
    checkOutput("saturated beat reached output", seen, 1);
    @(posedge clk_in);
    #1;
    @(negedge clk_in);
    checkOutput("sticky set wins over clear", sat_sticky_out, 1);
    @(posedge clk_in);
    #1;
    clear_in = 1'b0;
    waitDrain();
    repeat (2) @(posedge clk_in);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
